seq_borrow_sub: RTL
===================

Name: seq_borrow_sub

Overview:
Iterative WIDTH-bit subtractor producing diff = a - b - bin, one SLICE-bit slice per clock. It is the borrow/decrement counterpart of the carry-increment adder path. Each slice forms a raw slice difference, then conditionally decrements it by the incoming borrow through a borrow-decrement slice. It sits beside the adder in the ALU datapath and uses a valid/ready handshake on both sides.

Parameters:
WIDTH, 32, operand and result width; must be a multiple of SLICE.
SLICE, 8, bits processed per cycle.
NSLICE, WIDTH/SLICE, derived localparam; number of RUN cycles.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  borrow-out; 1 when a < b + bin as unsigned values
busy  output  1  high in RUN or DONE

Behaviour:
- Reset is asynchronous and active-high. While rst=1, the block enters IDLE and clears all registers: in_ready=1, out_valid=0, diff=0, bout=0, busy=0. Asserting reset mid-operation aborts the operation and discards it.
- States are IDLE, RUN and DONE.
- IDLE: in_ready=1. When in_valid=1 at a clock edge, the block captures a, b and bin, sets slice index to 0, loads the borrow register with bin, and moves to RUN. in_ready=0 in every other state; in_valid outside IDLE is ignored.
- RUN: each cycle processes slice k = index. Bit range is [k*SLICE +: SLICE].
  - raw = {1'b0,a_k} - {1'b0,b_k}, computed SLICE+1 bits wide. raw_borrow = raw[SLICE].
  - dec_in = raw[SLICE-1:0]. This goes into the decrement slice with the borrow register as dec_bin.
  - The decrement slice returns res_k = dec_in - dec_bin and dec_bout = dec_bin & (dec_in == 0).
  - The block writes res_k into diff slice k. Borrow register <= raw_borrow | dec_bout. The two terms are never both 1, because raw_borrow=1 implies dec_in is nonzero.
  - The index increments. After slice NSLICE-1, bout <= the final borrow, out_valid <= 1, and the state moves to DONE.
- DONE: out_valid=1. diff and bout hold stable while out_ready=0. When out_ready=1, out_valid drops on the next edge and the state moves to IDLE.
- diff is not valid outside DONE. Its partial contents during RUN are not guaranteed to consumers.
- Latency: out_valid rises NSLICE cycles after the accepting edge (4 cycles for the defaults). Minimum initiation interval is NSLICE+2 cycles.
- Wrap-around: diff is modulo 2^WIDTH. 0 - 1 yields all-ones with bout=1.
- Simultaneous events: out_ready and in_valid in the same DONE cycle do not chain. The new operand is accepted only after returning to IDLE.

Decomposition:
- Shared ALU package holds: the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default WIDTH/SLICE constants, and an index width of clog2(NSLICE).
- One sub-module, decr_slice (SLICE-bit borrow-decrement): ports a, bin, diff, bout. It is purely combinational and mirrors the incrementer slice used by the adder.

Test Plan:
- a=0x00000005, b=0x00000003, bin=0 -> diff=0x00000002, bout=0; out_valid exactly 4 cycles after acceptance.
- a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1; borrow ripples through all four slices.
- a=0x00010000, b=0x00000000, bin=1 -> diff=0x0000FFFF, bout=0; the decrement slice propagates through two zero slices.
- a=0x12345678, b=0x12345678, bin=1 -> diff=0xFFFFFFFF, bout=1. Also a=0xFFFFFFFF, b=0x00000001, bin=1 -> diff=0xFFFFFFFD, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> diff, bout and out_valid stable, in_ready=0, a second in_valid ignored. Release out_ready -> IDLE next cycle, then the new operand is accepted.
- Assert rst during RUN cycle 2 -> immediately out_valid=0, diff=0, in_ready=1. A fresh a=0x100, b=0x1 then yields diff=0xFF, bout=0.

Source files
------------

// File: rtl/seq_borrow_sub_pkg.sv
// Shared ALU definitions for the sequential borrow subtractor: state encoding,
// default geometry and the slice-index width helper.
package seq_borrow_sub_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefSlice = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // A single-slice datapath still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/decr_slice.sv
// SLICE-bit borrow-decrement slice: diff = a - bin, borrow out when a is zero.
// Purely combinational; the decrement counterpart of the adder's increment slice.
module decr_slice
    import seq_borrow_sub_pkg::*;
#(
    parameter int unsigned SLICE = DefSlice
) (
    input  logic [SLICE-1:0] a_i,
    input  logic             bin_i,
    output logic [SLICE-1:0] diff_o,
    output logic             bout_o
);

    assign diff_o = a_i - SLICE'(bin_i);
    assign bout_o = bin_i & (a_i == '0);

endmodule

// File: rtl/seq_borrow_sub.sv
// Iterative WIDTH-bit subtractor: diff = a - b - bin, one SLICE-bit slice per
// clock, with valid/ready handshakes on operand and result sides.
module seq_borrow_sub
    import seq_borrow_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned SLICE = DefSlice
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             busy_o
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IdxW   = idx_width(NSLICE);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              borrow_q, borrow_d;
    logic              bout_q, bout_d;

    logic [SLICE-1:0]  a_k, b_k, res_k;
    logic [SLICE:0]    raw;
    logic              dec_bout;
    logic              borrow_nxt;

    assign a_k = a_q[idx_q*SLICE +: SLICE];
    assign b_k = b_q[idx_q*SLICE +: SLICE];
    assign raw = {1'b0, a_k} - {1'b0, b_k};

    decr_slice #(
        .SLICE (SLICE)
    ) u_decr (
        .a_i    (raw[SLICE-1:0]),
        .bin_i  (borrow_q),
        .diff_o (res_k),
        .bout_o (dec_bout)
    );

    // raw borrow implies a nonzero low part, so at most one term is ever set.
    assign borrow_nxt = raw[SLICE] | dec_bout;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    idx_d    = '0;
                    borrow_d = bin_i;
                    state_d  = StRun;
                end
            end
            StRun: begin
                diff_d[idx_q*SLICE +: SLICE] = res_k;
                borrow_d = borrow_nxt;
                idx_d    = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    bout_d  = borrow_nxt;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q == StRun) || (state_q == StDone);
    assign diff_o      = diff_q;
    assign bout_o      = bout_q;

endmodule
